alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_serial_shifter.sv | 42 ++++
 rtl/alu_exec_unit.sv | 115 +++++++++++
 tb/tb_alu_exec_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and state definitions, plus the ALU control decoder, for the ALU execution unit.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CTRL_W  = 3;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [CTRL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  typedef struct packed {
    alu_op_e           op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_req_t;

  function automatic logic is_shift(alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

  // Single-cycle result; shift codes pass src_a through, which is only used for a zero amount.
  function automatic logic [DATA_W-1:0] alu_comb(alu_req_t req);
    logic [DATA_W-1:0] r;
    r = req.a;
    case (req.op)
      ALU_ADD: r = req.a + req.b;
      ALU_SUB: r = req.a - req.b;
      ALU_AND: r = req.a & req.b;
      ALU_OR:  r = req.a | req.b;
      ALU_XOR: r = req.a ^ req.b;
      ALU_SLT: r = {{(DATA_W-1){1'b0}}, ($signed(req.a) < $signed(req.b))};
      default: r = req.a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Bit-serial shifter: one bit position per cycle until the loaded count is exhausted.
module alu_serial_shifter
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               dir_right_i,
  input  logic [DATA_W-1:0]  operand_i,
  input  logic [SHAMT_W-1:0] amount_i,
  output logic               done_c_o,
  output logic [DATA_W-1:0]  value_c_o
);

  logic [DATA_W-1:0]  opnd_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               dir_q;
  logic [DATA_W-1:0]  step_c;

  // Value after the pending step; once the count is spent the operand is already final.
  always_comb begin
    step_c    = dir_q ? (opnd_q >> 1) : (opnd_q << 1);
    value_c_o = (cnt_q == '0) ? opnd_q : step_c;
    done_c_o  = (cnt_q <= SHAMT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_q <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
    end else if (start_i) begin
      opnd_q <= operand_i;
      cnt_q  <= amount_i;
      dir_q  <= dir_right_i;
    end else if (cnt_q != '0) begin
      opnd_q <= step_c;
      cnt_q  <= cnt_q - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle arithmetic/logic, serial shifts, valid/ready on both sides.
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CTRL_W-1:0]   alu_ctrl,
  input  logic [DATA_W-1:0]   src_a,
  input  logic [DATA_W-1:0]   src_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   result,
  output logic                zero,
  output logic                busy
);

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               zero_q, zero_d;

  alu_req_t           req_c;
  logic               out_free_c;
  logic               accept_c;
  logic               sh_start_c;
  logic               sh_done_c;
  logic [DATA_W-1:0]  sh_value_c;
  logic               load_c;
  logic [DATA_W-1:0]  load_val_c;
  logic [SHAMT_W-1:0] shamt_c;

  assign req_c      = '{op: alu_op_e'(alu_ctrl), a: src_a, b: src_b};
  assign shamt_c    = src_b[SHAMT_W-1:0];
  assign out_free_c = !out_valid_q || out_ready;
  assign in_ready   = (state_q == ST_IDLE) && out_free_c;
  assign accept_c   = in_valid && in_ready;

  alu_serial_shifter u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (sh_start_c),
    .dir_right_i(req_c.op == ALU_SRL),
    .operand_i  (src_a),
    .amount_i   (shamt_c),
    .done_c_o   (sh_done_c),
    .value_c_o  (sh_value_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus the output-register load decision.
  always_comb begin
    state_d    = state_q;
    sh_start_c = 1'b0;
    load_c     = 1'b0;
    load_val_c = alu_comb(req_c);
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (is_shift(req_c.op) && (shamt_c != '0)) begin
            sh_start_c = 1'b1;
            state_d    = ST_SHIFT;
          end else begin
            load_c = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        load_val_c = sh_value_c;
        if (sh_done_c && out_free_c) begin
          load_c  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A load wins over consumption so back-to-back results keep out_valid high.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    if (load_c) begin
      out_valid_d = 1'b1;
      result_d    = load_val_c;
      zero_d      = (load_val_c == '0);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign busy      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table for single-cycle ops plus shift/stall/reset sequences.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_ctrl;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cons_cnt = 0;
  logic [31:0] cons_last = '0;

  alu_exec_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_ctrl (alu_ctrl),
    .src_a    (src_a),
    .src_b    (src_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Record every result handed to the consumer.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      cons_cnt  <= cons_cnt + 1;
      cons_last <= result;
    end
  end

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
  } vec_t;

  vec_t vecs [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    alu_ctrl = c;
    src_a    = a;
    src_b    = b;
  endtask

  initial begin
    int cons0;
    int bad;

    vecs[0]  = '{3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
    vecs[1]  = '{3'b001, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1};
    vecs[2]  = '{3'b101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    vecs[3]  = '{3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0};
    vecs[4]  = '{3'b011, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0};
    vecs[5]  = '{3'b100, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 1'b1};
    vecs[6]  = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    vecs[7]  = '{3'b001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0};
    vecs[8]  = '{3'b101, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[9]  = '{3'b101, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0};
    vecs[10] = '{3'b110, 32'h12345678, 32'h00000000, 32'h12345678, 1'b0};
    vecs[11] = '{3'b111, 32'h80000000, 32'h00000020, 32'h80000000, 1'b0};

    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 3'b000, '0, '0);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result",    result,         32'd0);
    chk("rst_zero",      32'(zero),      32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    step();
    step();
    #2 rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single-cycle ops back to back with out_ready held high: one result per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b);
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      step();
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_result", i),    result,         vecs[i].res);
      chk($sformatf("v%0d_zero", i),      32'(zero),      32'(vecs[i].z));
      chk($sformatf("v%0d_busy", i),      32'(busy),      32'd0);
    end

    // sll 1 by 31: busy for 31 cycles, a held request waits, result at the 31st edge after accept.
    drive(1'b1, 3'b110, 32'h00000001, 32'h0000001F);
    #1;
    chk("sll_accept_ready", 32'(in_ready), 32'd1);
    step();
    drive(1'b1, 3'b000, 32'h00000002, 32'h00000003);
    for (int i = 0; i < 31; i++) begin
      chk($sformatf("sll_busy_c%0d", i),      32'(busy),      32'd1);
      chk($sformatf("sll_in_ready_c%0d", i),  32'(in_ready),  32'd0);
      chk($sformatf("sll_out_valid_c%0d", i), 32'(out_valid), 32'd0);
      step();
    end
    chk("sll_done_valid",  32'(out_valid), 32'd1);
    chk("sll_done_result", result,         32'h80000000);
    chk("sll_done_zero",   32'(zero),      32'd0);
    chk("sll_done_busy",   32'(busy),      32'd0);
    step();
    chk("held_add_valid",  32'(out_valid), 32'd1);
    chk("held_add_result", result,         32'h00000005);

    // Result 5 pending with consumer stalled; srl presented and held.
    out_ready = 1'b0;
    drive(1'b1, 3'b111, 32'h80000000, 32'hFFFFFFE4);
    cons0 = cons_cnt;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall_in_ready_c%0d", i), 32'(in_ready),  32'd0);
      chk($sformatf("stall_valid_c%0d", i),    32'(out_valid), 32'd1);
      chk($sformatf("stall_result_c%0d", i),   result,         32'h00000005);
      step();
    end
    out_ready = 1'b1;
    step();
    drive(1'b0, 3'b000, '0, '0);
    chk("srl_busy",       32'(busy),      32'd1);
    chk("srl_prior_gone", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("srl_wait_valid_c%0d", i), 32'(out_valid), 32'd0);
    end
    step();
    chk("srl_valid",      32'(out_valid),   32'd1);
    chk("srl_result",     result,           32'h08000000);
    chk("srl_zero",       32'(zero),        32'd0);
    chk("srl_busy_done",  32'(busy),        32'd0);
    chk("prior_consumed", 32'(cons_cnt - cons0), 32'd1);
    chk("prior_value",    cons_last,        32'h00000005);

    // Reset in the middle of a 20-bit shift, with 10 steps left.
    drive(1'b1, 3'b110, 32'h00000003, 32'h00000014);
    step();
    drive(1'b0, 3'b000, '0, '0);
    for (int i = 0; i < 10; i++) step();
    chk("mid_shift_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",  32'(out_valid), 32'd0);
    chk("mid_rst_result", result,         32'd0);
    chk("mid_rst_zero",   32'(zero),      32'd0);
    chk("mid_rst_busy",   32'(busy),      32'd0);
    step();
    step();
    #2 rst_n = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (out_valid || busy) bad++;
    end
    chk("no_result_after_rst", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
